hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: data-hazard bubbles, taken-branch flushes and
// data-memory wait freezes, with a wait timeout that parks the pipe in ERROR.
`ifndef REG_FILE_DEPTH
`define REG_FILE_DEPTH 4
`endif

module hazard_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`REG_FILE_DEPTH-1:0] src1,
    input  logic [`REG_FILE_DEPTH-1:0] src2,
    input  logic                       src1_valid,
    input  logic                       src2_valid,
    input  logic [`REG_FILE_DEPTH-1:0] exe_dst,
    input  logic [`REG_FILE_DEPTH-1:0] mem_dst,
    input  logic                       exe_wb_en,
    input  logic                       mem_wb_en,
    input  logic                       exe_mem_read,
    input  logic                       forward_en,
    input  logic                       branch_taken,
    input  logic                       mem_req,
    input  logic                       mem_ready,
    output logic                       freeze_if,
    output logic                       freeze_id,
    output logic                       bubble_id,
    output logic                       flush,
    output logic                       freeze_exe_mem,
    output logic                       mem_timeout,
    output logic [CNT_WIDTH-1:0]       hazard_count,
    output logic [1:0]                 state
);
    // state    | meaning
    // RUN      | normal issue; data hazards bubble ID, taken branches flush
    // MEM_WAIT | data memory busy; whole pipe frozen while the wait counter runs
    // ERROR    | memory never answered; pipe frozen until rst
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2,
        S_UNUSED   = 2'd3
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t              cur_state;
    state_t              nxt_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                hazard1;
    logic                hazard2;
    logic                hazard;
    logic                mem_stall;
    logic                count_hazard;
    logic                wait_load;
    logic                wait_inc;
    logic                set_timeout;

    // With forwarding only a load in EXE cannot be bypassed in time.
    always_comb begin
        if (forward_en) begin
            hazard1 = src1_valid && exe_wb_en && exe_mem_read && (src1 == exe_dst);
            hazard2 = src2_valid && exe_wb_en && exe_mem_read && (src2 == exe_dst);
        end else begin
            hazard1 = src1_valid && ((exe_wb_en && (src1 == exe_dst)) ||
                                     (mem_wb_en && (src1 == mem_dst)));
            hazard2 = src2_valid && ((exe_wb_en && (src2 == exe_dst)) ||
                                     (mem_wb_en && (src2 == mem_dst)));
        end
    end

    assign hazard    = hazard1 || hazard2;
    assign mem_stall = mem_req && !mem_ready;
    assign state     = cur_state;

    always_comb begin
        freeze_if      = 1'b0;
        freeze_id      = 1'b0;
        bubble_id      = 1'b0;
        flush          = 1'b0;
        freeze_exe_mem = 1'b0;
        count_hazard   = 1'b0;
        wait_load      = 1'b0;
        wait_inc       = 1'b0;
        set_timeout    = 1'b0;
        nxt_state      = cur_state;

        case (cur_state)
            S_RUN: begin
                if (mem_stall) begin
                    freeze_if      = 1'b1;
                    freeze_id      = 1'b1;
                    freeze_exe_mem = 1'b1;
                    wait_load      = 1'b1;
                    nxt_state      = S_MEM_WAIT;
                end else if (branch_taken) begin
                    flush     = 1'b1;
                    bubble_id = 1'b1;
                end else if (hazard) begin
                    freeze_if    = 1'b1;
                    freeze_id    = 1'b1;
                    bubble_id    = 1'b1;
                    count_hazard = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (!mem_ready) begin
                    freeze_if      = 1'b1;
                    freeze_id      = 1'b1;
                    freeze_exe_mem = 1'b1;
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        set_timeout = 1'b1;
                        nxt_state   = S_ERROR;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end else begin
                    // Completion cycle: the pipe moves again, so ID is judged as in RUN.
                    nxt_state = S_RUN;
                    if (branch_taken) begin
                        flush     = 1'b1;
                        bubble_id = 1'b1;
                    end else if (hazard) begin
                        freeze_if    = 1'b1;
                        freeze_id    = 1'b1;
                        bubble_id    = 1'b1;
                        count_hazard = 1'b1;
                    end
                end
            end
            S_ERROR: begin
                freeze_if      = 1'b1;
                freeze_id      = 1'b1;
                freeze_exe_mem = 1'b1;
            end
            default: nxt_state = S_RUN;
        endcase

        if (rst) begin
            freeze_if      = 1'b0;
            freeze_id      = 1'b0;
            bubble_id      = 1'b0;
            flush          = 1'b0;
            freeze_exe_mem = 1'b0;
            count_hazard   = 1'b0;
            wait_load      = 1'b0;
            wait_inc       = 1'b0;
            set_timeout    = 1'b0;
            nxt_state      = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= S_RUN;
            wait_cnt     <= '0;
            hazard_count <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (wait_load) begin
                wait_cnt <= WAIT_W'(1);
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (set_timeout) begin
                mem_timeout <= 1'b1;
            end
            if (count_hazard && (hazard_count != '1)) begin
                hazard_count <= hazard_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
